alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared ALU. It accepts operation requests from two clients over valid/ready handshakes and grants them round-robin. It drives the external ALU combinational ports with registered operands, captures result and flags, and returns them to the granted client. Division and modulo by zero, and unused opcodes, are rejected without using the ALU.

## Interface
- WIDTH, 32, operand/result width; must match the attached ALU instance.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- req_a  in  2*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand B, same packing.
- req_ci  in  2  carry-in per requester.
- req_op  in  8  4-bit opcode per requester, at [i*4 +: 4].
- rsp_valid  out  2  response valid, bit i = requester i.
- rsp_ready  in  2  response accept per requester.
- rsp_result  out  WIDTH  result of the operation being returned.
- rsp_flags  out  4  {N,Z,C,V} of the operation being returned.
- rsp_err  out  1  1 = operation rejected; result and flags are 0.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_ci  out  1  carry-in to the ALU.
- alu_op  out  4  ALU selector.
- alu_result  in  WIDTH  ALU result.
- alu_n, alu_z, alu_c, alu_v  in  1  ALU flags.
- busy  out  1  high in any state other than IDLE.

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 MOD, 0101 AND, 0110 OR, 0111 XOR, 1000 SHL, 1001 SHR. Codes 1010–1111 are illegal.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - req_ready[g] = req_valid[g] for the grantee g only. Grant logic is combinational.
  - If one requester is valid, it wins.
  - If both are valid, the winner is the requester not recorded in last_grant.
  - On handshake, register operands, ci, op and id, and set last_grant = g.
- Legal op with B ≠ 0 or non-DIV/MOD op: go to EXEC.
- Illegal op, or DIV/MOD with B = 0: go to RESP with err = 1, result 0, flags 0.
- EXEC (exactly one cycle): alu_* are driven from the registered operands. At the clock edge, capture alu_result and {alu_n,alu_z,alu_c,alu_v} into the response registers, then go to RESP.
- RESP:
  - rsp_valid[id] = 1, and other bits 0. rsp_result, rsp_flags and rsp_err are held stable.
  - On rsp_ready[id], go to IDLE. rsp_ready of the non-owner is ignored.
- alu_* outputs always reflect the operand registers. They are 0 after reset, and the ALU output is only sampled in EXEC.
- A requester may change its request fields only after its handshake. Dropping valid before the handshake withdraws the request.

## Timing
- Reset values: state IDLE, last_grant = 1 (so requester 0 wins the first tie), all operand and response registers 0, rsp_valid 0, req_ready 0, busy 0, rsp_err 0.
- ALU path: handshake in cycle T, EXEC in T+1, rsp_valid in T+2.
- Rejected op: rsp_valid in T+1.
- Best-case throughput is one op per 3 cycles. The next request can be accepted in the cycle after the rsp handshake.
- No request is accepted while busy, so req_ready = 0 outside IDLE.
- Reset mid-operation: the in-flight op is dropped, no response is produced, and all outputs return to their reset values immediately, since reset is asynchronous.
- Arithmetic is WIDTH bits. Flags are passed through from the ALU unchanged, and the arbiter never computes them.

## Structure
- Package alu_pkg holds the opcode localparams (OP_ADD…OP_SHR), an is_legal_op function, the state enum typedef (IDLE/EXEC/RESP), and flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module, rr_arbiter2: inputs req[1:0] and last[0:0]; output one-hot grant[1:0].
- The ALU is instantiated outside and connected through the alu_* ports. The bench instantiates ALU #(4) with the arbiter at WIDTH=4.

## Test plan
- Req0 ADD, a=0111, b=0110, ci=1 → rsp_valid[0] two cycles after accept; result 1110, flags C=0, err=0.
- Both valid after reset: req0 SUB 1000−0110, req1 AND 1110&0111 → req0 is served first. req1 gets result 0110 next, with req_ready[1] first high in the IDLE cycle after rsp0's handshake.
- Sustained simultaneous requests over 6 ops → grants alternate 0,1,0,1,0,1, and req_ready is never high for both.
- Req1 DIV with b=0000, then req1 opcode 1100 → each gets rsp_valid one cycle after accept, err=1, result 0000, flags 0000, and alu_* is not re-sampled.
- Hold rsp_ready[0]=0 for 5 cycles, while toggling rsp_ready[1] and asserting req_valid[1] → rsp outputs stay stable, req_ready stays 0, and busy stays 1.
- Assert rst_n=0 during EXEC of MUL 1010×0110 → outputs go to reset values immediately. After release, no stale rsp_valid appears, and a fresh MOD 1000 mod 0101 returns 0011.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states, flag bit
// positions and opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_SHR;
  endfunction

  // Ops whose B operand must be non-zero for the ALU to be used.
  function automatic logic is_divmod(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [0:0] last,
  output logic [1:0] grant
);

  // NOTE: a default is assigned before the case so no path leaves grant
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last[0] ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two clients onto one external combinational ALU: registers the
// winning request, samples the ALU for one cycle and returns the response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  input  logic [1:0]           req_ci,
  input  logic [7:0]           req_op,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_ci,
  output logic [3:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_n,
  input  logic                 alu_z,
  input  logic                 alu_c,
  input  logic                 alu_v,
  output logic                 busy
);

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               ci_q, ci_d;
  logic [3:0]         op_q, op_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;

  logic [1:0]         grant;
  logic               sel_id;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [3:0]         sel_op;
  logic               sel_ci;
  logic               reject;

  rr_arbiter2 u_rr (
    .req   (req_valid),
    .last  (last_grant_q),
    .grant (grant)
  );

  assign sel_id = grant[1];
  assign sel_a  = sel_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign sel_b  = sel_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign sel_op = sel_id ? req_op[7:4] : req_op[3:0];
  assign sel_ci = req_ci[sel_id];
  assign reject = !is_legal_op(sel_op) || (is_divmod(sel_op) && (sel_b == '0));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    ci_d         = ci_q;
    op_d         = op_q;
    id_d         = id_q;
    result_d     = result_q;
    flags_d      = flags_q;
    err_d        = err_q;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;

    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          a_d          = sel_a;
          b_d          = sel_b;
          ci_d         = sel_ci;
          op_d         = sel_op;
          id_d         = sel_id;
          last_grant_d = sel_id;
          if (reject) begin
            // Rejected ops skip the ALU entirely and answer with zeros.
            result_d = '0;
            flags_d  = '0;
            err_d    = 1'b1;
            state_d  = RESP;
          end else begin
            err_d    = 1'b0;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        result_d         = alu_result;
        flags_d[FLAG_N]  = alu_n;
        flags_d[FLAG_Z]  = alu_z;
        flags_d[FLAG_C]  = alu_c;
        flags_d[FLAG_V]  = alu_v;
        err_d            = 1'b0;
        state_d          = RESP;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        if (rsp_ready[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of evaluation order.
  // NOTE: the operand and response registers are reset as well, because they
  // drive alu_* and rsp_* directly and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      ci_q         <= 1'b0;
      op_q         <= '0;
      id_q         <= 1'b0;
      result_q     <= '0;
      flags_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ci_q         <= ci_d;
      op_q         <= op_d;
      id_q         <= id_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ci     = ci_q;
  assign alu_op     = op_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter at WIDTH=4 with a behavioural 4-bit ALU
// attached to the alu_* ports.
module tb_alu_arbiter;

  localparam int W = 4;

  localparam logic [3:0] T_ADD = 4'b0000;
  localparam logic [3:0] T_SUB = 4'b0001;
  localparam logic [3:0] T_MUL = 4'b0010;
  localparam logic [3:0] T_DIV = 4'b0011;
  localparam logic [3:0] T_MOD = 4'b0100;
  localparam logic [3:0] T_AND = 4'b0101;
  localparam logic [3:0] T_OR  = 4'b0110;
  localparam logic [3:0] T_XOR = 4'b0111;
  localparam logic [3:0] T_SHL = 4'b1000;
  localparam logic [3:0] T_SHR = 4'b1001;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_ci;
  logic [7:0]     req_op;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_result;
  logic [3:0]     rsp_flags;
  logic           rsp_err;
  logic [W-1:0]   alu_a, alu_b;
  logic           alu_ci;
  logic [3:0]     alu_op;
  logic [W-1:0]   alu_result;
  logic           alu_n, alu_z, alu_c, alu_v;
  logic           busy;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ci     (req_ci),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ci     (alu_ci),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .busy       (busy)
  );

  // Behavioural ALU; div/mod by zero and unused codes produce distinctive
  // non-zero outputs so any wrongful sampling shows up in the response.
  logic [W:0] m_sum;
  logic       m_force;
  always_comb begin
    m_sum      = '0;
    m_force    = 1'b0;
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_op)
      T_ADD: begin
        m_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_ci};
        alu_result = m_sum[W-1:0];
        alu_c      = m_sum[W];
        alu_v      = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      T_SUB: begin
        alu_result = alu_a - alu_b;
        alu_c      = (alu_a >= alu_b);
        alu_v      = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      T_MUL: alu_result = alu_a * alu_b;
      T_DIV: alu_result = (alu_b == '0) ? '1 : alu_a / alu_b;
      T_MOD: alu_result = (alu_b == '0) ? '1 : alu_a % alu_b;
      T_AND: alu_result = alu_a & alu_b;
      T_OR:  alu_result = alu_a | alu_b;
      T_XOR: alu_result = alu_a ^ alu_b;
      T_SHL: alu_result = alu_a << alu_b;
      T_SHR: alu_result = alu_a >> alu_b;
      default: begin
        alu_result = alu_a;
        m_force    = 1'b1;
        alu_c      = 1'b1;
        alu_v      = 1'b1;
      end
    endcase
    alu_n = m_force | alu_result[W-1];
    alu_z = m_force | (alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] result;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   both_ready_viol = 0;
  int   both_rsp_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [3:0] res, input logic [3:0] flg, input logic err);
    exp_t e;
    e.id = id; e.result = res; e.flags = flg; e.err = err;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (&req_ready) both_ready_viol++;
      if (&rsp_valid) both_rsp_viol++;
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          check("rsp_expected", 32'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rsp_id", i, e.id);
            check("rsp_result", rsp_result, e.result);
            check("rsp_flags", rsp_flags, e.flags);
            check("rsp_err", rsp_err, e.err);
          end
        end
      end
    end
  end

  task automatic drive_req(input int id, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic ci);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_op[id*4 +: 4] = op;
    req_ci[id]        = ci;
    req_valid[id]     = 1'b1;
  endtask

  task automatic wait_ready(input int id);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
    end
    check("req_ready_seen", 32'(ok), 1);
  endtask

  task automatic wait_rsp(input int id, output int lat);
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clk);
      if (rsp_valid[id]) lat = n;
    end
  endtask

  // Full transaction: accept, drop valid, measure latency to rsp_valid.
  task automatic issue(input string name, input int id, input logic [3:0] op,
                       input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [3:0] res, input logic [3:0] flg, input logic err,
                       input int exp_lat);
    int lat;
    push(id[0], res, flg, err);
    drive_req(id, op, a, b, ci);
    wait_ready(id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    wait_rsp(id, lat);
    check({name, "_latency"}, lat, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ci    = '0;
    req_op    = '0;
    rsp_ready = 2'b11;
    do_reset();

    @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_ci", alu_ci, 0);
    @(posedge clk); #1;

    issue("add", 0, T_ADD, 4'b0111, 4'b0110, 1'b1, 4'b1110, 4'b1001, 1'b0, 2);
    issue("div", 1, T_DIV, 4'b1001, 4'b0010, 1'b0, 4'b0100, 4'b0000, 1'b0, 2);
    issue("and_zero", 0, T_AND, 4'b1010, 4'b0101, 1'b0, 4'b0000, 4'b0100, 1'b0, 2);
    issue("shr", 1, T_SHR, 4'b1100, 4'b0010, 1'b0, 4'b0011, 4'b0000, 1'b0, 2);

    // Tie straight after reset: requester 0 first, requester 1 right after.
    do_reset();
    push(1'b0, 4'b0010, 4'b0011, 1'b0);
    push(1'b1, 4'b0110, 4'b0000, 1'b0);
    drive_req(0, T_SUB, 4'b1000, 4'b0110, 1'b0);
    drive_req(1, T_AND, 4'b1110, 4'b0111, 1'b0);
    @(negedge clk);
    check("tie_first_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("tie_exec_ready", req_ready, 2'b00);
    check("tie_exec_busy", busy, 1);
    @(negedge clk);
    check("tie_rsp0_valid", rsp_valid, 2'b01);
    check("tie_rsp0_ready", req_ready, 2'b00);
    @(negedge clk);
    check("tie_req1_ready", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, lat);
    check("tie_rsp1_latency", lat, 2);
    @(posedge clk); #1;

    // Sustained contention: grants must alternate starting with requester 0.
    drive_req(0, T_XOR, 4'b1010, 4'b0110, 1'b0);
    drive_req(1, T_OR,  4'b0001, 4'b0100, 1'b0);
    for (int k = 0; k < 6; k++) begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (|req_ready) seen = 1'b1;
      end
      check("sus_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k % 2) push(1'b1, 4'b0101, 4'b0000, 1'b0);
      else       push(1'b0, 4'b1100, 4'b1000, 1'b0);
      @(posedge clk); #1;
      if (k == 5) req_valid = 2'b00;
    end
    wait_rsp(1, lat);
    check("sus_last_latency", lat, 2);
    @(posedge clk); #1;

    // Rejections answer one cycle after accept with zeros and err set.
    issue("div0", 1, T_DIV, 4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1);
    issue("illegal", 1, 4'b1100, 4'b0011, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b1, 1);
    check("illegal_alu_op_reg", alu_op, 4'b1100);
    issue("mod0", 0, T_MOD, 4'b0111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1);

    // Response back-pressure while the other requester pokes at the arbiter.
    rsp_ready[0] = 1'b0;
    push(1'b0, 4'b0110, 4'b0000, 1'b0);
    drive_req(0, T_SHL, 4'b0011, 4'b0001, 1'b0);
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, lat);
    check("hold_latency", lat, 2);
    push(1'b1, 4'b0011, 4'b0000, 1'b0);
    drive_req(1, T_AND, 4'b1111, 4'b0011, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      rsp_ready[1] = ~rsp_ready[1];
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 2'b01);
      check("hold_rsp_result", rsp_result, 4'b0110);
      check("hold_rsp_flags", rsp_flags, 4'b0000);
      check("hold_rsp_err", rsp_err, 0);
      check("hold_req_ready", req_ready, 2'b00);
      check("hold_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_ready(1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, lat);
    check("after_hold_latency", lat, 2);
    @(posedge clk); #1;

    // Asynchronous reset while a MUL sits in EXEC.
    drive_req(0, T_MUL, 4'b1010, 4'b0110, 1'b0);
    wait_ready(0);
    @(posedge clk); #1;
    check("mul_in_exec_busy", busy, 1);
    check("mul_in_exec_op", alu_op, T_MUL);
    #1;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rsp_valid", rsp_valid, 2'b00);
    check("arst_req_ready", req_ready, 2'b00);
    check("arst_rsp_err", rsp_err, 0);
    check("arst_rsp_result", rsp_result, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_b", alu_b, 0);
    check("arst_alu_op", alu_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 2'b00);
    end
    @(posedge clk); #1;
    issue("mod", 0, T_MOD, 4'b1000, 4'b0101, 1'b0, 4'b0011, 4'b0000, 1'b0, 2);

    repeat (2) @(posedge clk);
    check("never_both_req_ready", both_ready_viol, 0);
    check("never_both_rsp_valid", both_rsp_viol, 0);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
